// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall control for the pipelined MIPS core.
// Tracks EX plus DEPTH downstream producer tags in a private shift pipe.
module fwd_hazard_ctrl #(
    parameter int AW        = 4,
    parameter int NRP       = 2,
    parameter int DEPTH     = 2,
    parameter int LOAD_SLOT = 2,
    localparam int SW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [NRP*AW-1:0] id_rn,
    input  logic [NRP-1:0]    id_re,
    input  logic [AW-1:0]     id_wn,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [NRP*SW-1:0] fwd_sel,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [15:0]       lu_stall_cnt
);

    logic [DEPTH:0]           v_q;
    logic [DEPTH:0]           we_q;
    logic [DEPTH:0]           ld_q;
    logic [AW-1:0]            wn_q [0:DEPTH];
    logic [NRP-1:0][AW-1:0]   rn_q;
    logic [NRP-1:0]           re_q;
    logic [15:0]              cnt_q;
    logic                     lu_hit;
    logic                     found;
    logic                     issue;

    // Loads still short of LOAD_SLOT cannot feed ID's consumer yet
    always_comb begin
        lu_hit = 1'b0;
        for (int j = 0; j < LOAD_SLOT - 1; j++) begin
            for (int p = 0; p < NRP; p++) begin
                if (v_q[j] && we_q[j] && ld_q[j] && wn_q[j] != '0 &&
                    id_re[p] && id_rn[p*AW +: AW] == wn_q[j]) begin
                    lu_hit = 1'b1;
                end
            end
        end
    end

    assign stall_id = lu_hit && id_valid && !flush_i;
    assign issue    = id_valid && !flush_i && !stall_id;

    always_comb begin
        fwd_sel = '0;
        found   = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            found = 1'b0;
            for (int s = 1; s <= DEPTH; s++) begin
                if (!found && v_q[s] && we_q[s] && wn_q[s] != '0 &&
                    re_q[p] && rn_q[p] == wn_q[s] &&
                    !(ld_q[s] && s < LOAD_SLOT)) begin
                    fwd_sel[p*SW +: SW] = SW'(s);
                    found = 1'b1;
                end
            end
        end
        if (!v_q[0]) begin
            fwd_sel = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            we_q  <= '0;
            ld_q  <= '0;
            rn_q  <= '0;
            re_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k <= DEPTH; k++) begin
                wn_q[k] <= '0;
            end
        end else if (!hold_i) begin
            for (int k = DEPTH; k > 0; k--) begin
                v_q[k]  <= v_q[k-1];
                we_q[k] <= we_q[k-1];
                ld_q[k] <= ld_q[k-1];
                wn_q[k] <= wn_q[k-1];
            end
            v_q[0]  <= issue;
            we_q[0] <= id_we;
            ld_q[0] <= id_is_load;
            wn_q[0] <= id_wn;
            rn_q    <= id_rn;
            re_q    <= id_re;
            if (stall_id && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign ex_valid     = v_q[0];
    assign lu_stall_cnt = cnt_q;

endmodule
